// File: rtl/intel_iopll_reset_sequencer.sv
// IOPLL reset sequencer: pulses the PLL reset, waits for lock, qualifies it as
// stable, retries on timeout or lock loss, and reports lock health.
module intel_iopll_reset_sequencer #(
  parameter int RESET_HOLD_CYCLES   = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked_in,
  input  logic       restart_req,
  output logic       pll_rst_out,
  output logic       reset_out,
  output logic       locked_out,
  output logic       lock_fail,
  output logic [7:0] lock_loss_count
);

  localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int TMO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int STB_W  = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int ATT_W  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [ATT_W-1:0]  ATT_MAX   = ATT_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_LOCKED,
    S_FAILED
  } state_t;

  state_t              r_state;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [TMO_W-1:0]    r_tmo_cnt;
  logic [STB_W-1:0]    r_stb_cnt;
  logic [ATT_W-1:0]    r_att_cnt;
  logic [7:0]          r_loss_cnt;
  logic                r_lock_s1;
  logic                r_lock_s2;

  state_t              w_state_nxt;
  logic [HOLD_W-1:0]   w_hold_nxt;
  logic [TMO_W-1:0]    w_tmo_nxt;
  logic [STB_W-1:0]    w_stb_nxt;
  logic [ATT_W-1:0]    w_att_nxt;
  logic [7:0]          w_loss_nxt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  // Two-flop synchronizer for the asynchronous PLL locked signal
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
    end else begin
      r_lock_s1 <= pll_locked_in;
      r_lock_s2 <= r_lock_s1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_RESET_PLL;
      r_hold_cnt <= '0;
      r_tmo_cnt  <= '0;
      r_stb_cnt  <= '0;
      r_att_cnt  <= '0;
      r_loss_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_tmo_cnt  <= w_tmo_nxt;
      r_stb_cnt  <= w_stb_nxt;
      r_att_cnt  <= w_att_nxt;
      r_loss_cnt <= w_loss_nxt;
    end
  end

  // restart_req overrides every transition, including a lock loss in LOCKED
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_tmo_nxt   = r_tmo_cnt;
    w_stb_nxt   = r_stb_cnt;
    w_att_nxt   = r_att_cnt;
    w_loss_nxt  = r_loss_cnt;
    if (restart_req) begin
      w_state_nxt = S_RESET_PLL;
      w_hold_nxt  = '0;
      w_att_nxt   = '0;
    end else begin
      case (r_state)
        S_RESET_PLL: begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_state_nxt = S_WAIT_LOCK;
            w_tmo_nxt   = '0;
          end else begin
            w_hold_nxt = r_hold_cnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (r_lock_s2) begin
            w_state_nxt = S_STABILIZE;
            w_stb_nxt   = '0;
          end else if (r_tmo_cnt == TMO_LAST) begin
            if (r_att_cnt < ATT_MAX) begin
              w_att_nxt   = r_att_cnt + 1'b1;
              w_state_nxt = S_RESET_PLL;
              w_hold_nxt  = '0;
            end else begin
              w_state_nxt = S_FAILED;
            end
          end else begin
            w_tmo_nxt = r_tmo_cnt + 1'b1;
          end
        end
        S_STABILIZE: begin
          if (!r_lock_s2) begin
            w_state_nxt = S_WAIT_LOCK;
            w_tmo_nxt   = '0;
          end else if (r_stb_cnt == STB_LAST) begin
            w_state_nxt = S_LOCKED;
            w_att_nxt   = '0;
          end else begin
            w_stb_nxt = r_stb_cnt + 1'b1;
          end
        end
        S_LOCKED: begin
          if (!r_lock_s2) begin
            w_state_nxt = S_RESET_PLL;
            w_hold_nxt  = '0;
            w_loss_nxt  = sat_inc8(r_loss_cnt);
          end
        end
        S_FAILED: begin
          w_state_nxt = S_FAILED;
        end
        default: begin
          w_state_nxt = S_RESET_PLL;
          w_hold_nxt  = '0;
        end
      endcase
    end
  end

  assign pll_rst_out     = (r_state == S_RESET_PLL);
  assign reset_out       = (r_state != S_LOCKED);
  assign locked_out      = (r_state == S_LOCKED);
  assign lock_fail       = (r_state == S_FAILED);
  assign lock_loss_count = r_loss_cnt;

endmodule

// File: tb/tb_intel_iopll_reset_sequencer.sv
// Bench for intel_iopll_reset_sequencer: vector table, directed corner sequences,
// and randomized lock/restart traffic against a timestamp-based reference model.
module tb_intel_iopll_reset_sequencer;

  localparam int HOLD  = 4;
  localparam int TMO   = 16;
  localparam int STB   = 8;
  localparam int RETRY = 2;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       lk      = 1'b0;
  logic       rq      = 1'b0;
  logic       pll_rst_out;
  logic       reset_out;
  logic       locked_out;
  logic       lock_fail;
  logic [7:0] lock_loss_count;

  int n_cmp = 0;
  int n_bad = 0;

  intel_iopll_reset_sequencer #(
    .RESET_HOLD_CYCLES  (HOLD),
    .LOCK_TIMEOUT_CYCLES(TMO),
    .LOCK_STABLE_CYCLES (STB),
    .MAX_RETRIES        (RETRY)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pll_locked_in  (lk),
    .restart_req    (rq),
    .pll_rst_out    (pll_rst_out),
    .reset_out      (reset_out),
    .locked_out     (locked_out),
    .lock_fail      (lock_fail),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       lock;
    int         ncyc;
    logic       prst;
    logic       rout;
    logic       lkd;
    logic       fail;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [15];

  // Reference model: phase plus the edge index at which it was entered
  int  m_phase;  // 0 reset_pll, 1 wait_lock, 2 stabilize, 3 locked, 4 failed
  int  m_t;
  int  m_entry;
  int  m_tries;
  int  m_loss;
  bit  m_hist[$];

  logic [7:0] pulses_cnt_dummy;
  logic       prst_h [151];
  logic       fail_h [151];
  int         pulses, bad_pulse, bad_gap, run, held_bad, run_left;
  logic       cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {pll_rst_out, reset_out, locked_out, lock_fail, lock_loss_count};
  endfunction

  task automatic check_outs(input string name, input logic prst, input logic rout,
                            input logic lkd, input logic fail, input logic [7:0] cnt);
    check(name, 32'(outs()), 32'({prst, rout, lkd, fail, cnt}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    lk = 1'b0;
    rq = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_locked(input string name);
    int k;
    k = 0;
    while (locked_out !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    check(name, 32'(locked_out), 32'd1);
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_t     = 0;
    m_entry = 0;
    m_tries = 0;
    m_loss  = 0;
    m_hist  = {1'b0, 1'b0};
  endtask

  task automatic model_enter(input int p);
    m_phase = p;
    m_entry = m_t;
  endtask

  task automatic model_edge(input bit lkv, input bit rqv);
    bit seen;
    int el;
    m_t++;
    seen = m_hist.pop_front();
    m_hist.push_back(lkv);
    el = m_t - m_entry;
    if (rqv) begin
      m_tries = 0;
      model_enter(0);
    end else begin
      case (m_phase)
        0: if (el == HOLD) model_enter(1);
        1: begin
          if (seen) model_enter(2);
          else if (el == TMO) begin
            if (m_tries < RETRY) begin
              m_tries++;
              model_enter(0);
            end else begin
              model_enter(4);
            end
          end
        end
        2: begin
          if (!seen) model_enter(1);
          else if (el == STB) begin
            m_tries = 0;
            model_enter(3);
          end
        end
        3: begin
          if (!seen) begin
            if (m_loss < 255) m_loss++;
            model_enter(0);
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [11:0] model_outs();
    return {m_phase == 0, m_phase != 3, m_phase == 3, m_phase == 4, 8'(m_loss)};
  endfunction

  initial begin
    tbl[0]  = '{1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 5,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 1,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{1'b1, 9,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[6]  = '{1'b1, 1,  1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[7]  = '{1'b1, 20, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[8]  = '{1'b0, 1,  1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[9]  = '{1'b0, 1,  1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[10] = '{1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[11] = '{1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[12] = '{1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[13] = '{1'b0, 15, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[14] = '{1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, 8'd1};

    // Normal lock, then a loss in LOCKED and the start of a retry
    do_reset();
    for (int i = 0; i < 15; i++) begin
      lk = tbl[i].lock;
      repeat (tbl[i].ncyc) tick();
      check_outs($sformatf("table_row%0d", i), tbl[i].prst, tbl[i].rout,
                 tbl[i].lkd, tbl[i].fail, tbl[i].cnt);
    end

    // Never lock: three reset pulses then FAILED
    do_reset();
    prst_h[0] = pll_rst_out;
    fail_h[0] = lock_fail;
    for (int i = 1; i <= 150; i++) begin
      tick();
      prst_h[i] = pll_rst_out;
      fail_h[i] = lock_fail;
    end
    pulses = 0; bad_pulse = 0; bad_gap = 0; held_bad = 0;
    cur = prst_h[0];
    run = 1;
    for (int i = 1; i <= 150; i++) begin
      if (prst_h[i] == cur) run++;
      else begin
        if (cur) begin
          pulses++;
          if (run != HOLD) bad_pulse++;
        end else if (run != TMO) begin
          bad_gap++;
        end
        cur = prst_h[i];
        run = 1;
      end
    end
    for (int i = 60; i <= 150; i++)
      if (fail_h[i] !== 1'b1 || prst_h[i] !== 1'b0) held_bad++;
    check("never_pulse_count", 32'(pulses), 32'(RETRY + 1));
    check("never_bad_pulse_len", 32'(bad_pulse), 32'd0);
    check("never_bad_gap_len", 32'(bad_gap), 32'd0);
    check("never_fail_before", 32'(fail_h[59]), 32'd0);
    check("never_fail_at", 32'(fail_h[60]), 32'd1);
    check("never_fail_held", 32'(held_bad), 32'd0);

    // Restart from FAILED
    rq = 1'b1;
    tick();
    rq = 1'b0;
    check("restart_failed_first", 32'({lock_fail, pll_rst_out}), 32'b01);
    repeat (3) tick();
    check("restart_failed_hold", 32'(pll_rst_out), 32'd1);
    tick();
    check("restart_failed_end", 32'(pll_rst_out), 32'd0);

    // Restart mid-RESET_PLL restarts the full hold
    do_reset();
    repeat (2) tick();
    rq = 1'b1;
    tick();
    rq = 1'b0;
    check("restart_mid_e3", 32'(pll_rst_out), 32'd1);
    tick();
    check("restart_mid_e4", 32'(pll_rst_out), 32'd1);
    repeat (2) tick();
    check("restart_mid_e6", 32'(pll_rst_out), 32'd1);
    tick();
    check("restart_mid_e7", 32'(pll_rst_out), 32'd0);

    // Glitch in STABILIZE: lock sampled high on edges 5..9, low on 10, high from 11
    do_reset();
    repeat (4) tick();
    for (int e = 5; e <= 25; e++) begin
      lk = ((e >= 5 && e <= 9) || e >= 11);
      tick();
      check($sformatf("glitch_e%0d", e), 32'({pll_rst_out, locked_out}), 32'({1'b0, e >= 21}));
    end

    // restart_req coincident with a lock loss leaves the count alone
    lk = 1'b0;
    tick();
    tick();
    rq = 1'b1;
    tick();
    rq = 1'b0;
    check_outs("restart_on_loss", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);

    // 300 lock losses saturate the counter
    lk = 1'b1;
    wait_locked("relock_before_losses");
    for (int i = 0; i < 300; i++) begin
      lk = 1'b0;
      tick();
      tick();
      lk = 1'b1;
      tick();
      wait_locked($sformatf("relock_%0d", i));
      check($sformatf("loss_count_%0d", i), 32'(lock_loss_count),
            32'((i + 1 > 255) ? 255 : i + 1));
    end

    // Asynchronous reset mid-STABILIZE
    lk = 1'b0;
    tick();
    tick();
    lk = 1'b1;
    repeat (8) tick();
    check_outs("stab_before_async", 1'b0, 1'b1, 1'b0, 1'b0, 8'd255);
    #2 reset_n = 1'b0;
    #1;
    check_outs("async_reset_values", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    #3 reset_n = 1'b1;
    lk = 1'b0;
    repeat (3) tick();
    check("after_async_e3", 32'(pll_rst_out), 32'd1);
    tick();
    check("after_async_e4", 32'(pll_rst_out), 32'd0);
    repeat (5) tick();
    lk = 1'b1;
    repeat (10) tick();
    check("after_async_e19", 32'(locked_out), 32'd0);
    tick();
    check("after_async_e20", 32'({locked_out, reset_out}), 32'b10);

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    run_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        lk = ~lk;
        if (lk) run_left = int'($urandom_range(40, 1));
        else if ($urandom_range(3, 0) == 0) run_left = int'($urandom_range(90, 40));
        else run_left = int'($urandom_range(20, 1));
      end
      run_left--;
      rq = ($urandom_range(99, 0) == 0);
      tick();
      model_edge(lk, rq);
      check($sformatf("rand_cyc%0d", i), 32'(outs()), 32'(model_outs()));
      if ($urandom_range(999, 0) == 0) begin
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check($sformatf("rand_async_cyc%0d", i), 32'(outs()), 32'(model_outs()));
        #2 reset_n = 1'b1;
      end
    end
    rq = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/intel_iopll_reset_sequencer.md
# intel_iopll_reset_sequencer

Drives the reset input of an IOPLL and supervises its locked output: it sequences the PLL out of reset, waits for lock, and qualifies lock as stable. It also re-issues PLL reset on timeout or loss of lock. It sits in the clock subsystem on the PLL's reference-clock domain, ahead of the locked-to-reset shim, and provides a qualified downstream reset plus lock health status.

## Interface
- RESET_HOLD_CYCLES, 64: cycles `pll_rst_out` is held high per PLL reset pulse; ≥1.
- LOCK_TIMEOUT_CYCLES, 65536: cycles allowed in WAIT_LOCK before a retry; ≥1.
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before lock is declared; ≥1.
- MAX_RETRIES, 3: PLL reset re-attempts after the initial one before FAILED; ≥0.

Ports:
- clk  in  1  free-running PLL reference clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset; deassertion is synchronized upstream.
- pll_locked_in  in  1  IOPLL locked, asynchronous; passes through a 2-flop synchronizer.
- restart_req  in  1  single-cycle request to restart the sequence.
- pll_rst_out  out  1  active-high reset to the IOPLL.
- reset_out  out  1  active-high downstream reset, low only in LOCKED.
- locked_out  out  1  qualified lock, high only in LOCKED.
- lock_fail  out  1  high only in FAILED.
- lock_loss_count  out  8  count of lock losses seen in LOCKED; saturates at 255.

## Operation
- States: RESET_PLL, WAIT_LOCK, STABILIZE, LOCKED, FAILED.
- Outputs are decoded from the state register only (Moore). There is no combinational path from any input to any output.
- Reset values: state RESET_PLL, hold and timeout counters 0, attempt counter 0, `pll_rst_out`=1, `reset_out`=1, `locked_out`=0, `lock_fail`=0, `lock_loss_count`=0, synchronizer flops 0.
- RESET_PLL: `pll_rst_out`=1. After RESET_HOLD_CYCLES cycles in the state, go to WAIT_LOCK and clear the timer.
- WAIT_LOCK: `pll_rst_out`=0.
  - Synchronized locked=1 → STABILIZE, with the stable counter at 0.
  - Otherwise, on the LOCK_TIMEOUT_CYCLES-th cycle: if attempts < MAX_RETRIES, increment attempts and go to RESET_PLL; else go to FAILED.
  - If lock is seen on the timeout cycle, lock wins.
- STABILIZE:
  - Synchronized locked=0 → WAIT_LOCK. The timer is cleared and no attempt is consumed.
  - After LOCK_STABLE_CYCLES consecutive high cycles → LOCKED, and attempts are cleared.
- LOCKED: `reset_out`=0, `locked_out`=1.
  - Synchronized locked=0 → RESET_PLL, and `lock_loss_count` increments (saturating).
- FAILED: `pll_rst_out`=0, `reset_out`=1, `lock_fail`=1. The block stays here until `restart_req` or reset.
- `restart_req` in any state:
  - Goes to RESET_PLL and clears the attempt counter and the hold counter.
  - Has priority over every other transition, including the RESET_PLL hold countdown.
  - When simultaneous with a lock loss in LOCKED, `lock_loss_count` does not increment.
- Counter widths: `$clog2(param+1)`.
- `lock_loss_count` holds at 255 and never wraps.

## Timing
- Assertion of `reset_n` forces all reset values asynchronously, including mid-STABILIZE and mid-RESET_PLL.
- `pll_rst_out` is high for exactly RESET_HOLD_CYCLES cycles per pulse, starting from reset release or from entry to RESET_PLL.
- With no lock, WAIT_LOCK lasts exactly LOCK_TIMEOUT_CYCLES cycles.
- Lock acquisition: let edge 0 be the first edge that samples `pll_locked_in`=1 while in WAIT_LOCK. Then state=STABILIZE at edge 2, and state=LOCKED (`locked_out`=1, `reset_out`=0) at edge LOCK_STABLE_CYCLES+2.
- Lock loss: let edge 0 be the first edge that samples `pll_locked_in`=0 while in LOCKED. Then at edge 2, `reset_out`=1, `locked_out`=0, `pll_rst_out`=1, and the count is updated.
- `restart_req` sampled at edge 0 → state=RESET_PLL from edge 1.
- With no lock ever, total `pll_rst_out` pulses = MAX_RETRIES+1 before FAILED.

## Test plan
Common parameters: HOLD=4, TIMEOUT=16, STABLE=8, RETRIES=2.

- **Normal lock.** Release `reset_n`; raise `pll_locked_in` 5 cycles after `pll_rst_out` falls → `pll_rst_out` high 4 cycles; `locked_out`=1 and `reset_out`=0 exactly 10 edges after lock is first sampled.
- **Never lock.** Hold `pll_locked_in`=0 → 3 pulses of `pll_rst_out`, each 4 cycles, separated by 16 low cycles; then `lock_fail`=1 with `pll_rst_out`=0 held indefinitely.
- **Glitch in STABILIZE.** Lock high 5 cycles, low 1, then high → no `locked_out` during the glitch and no extra `pll_rst_out` pulse; `locked_out` rises 10 edges after the relock sample.
- **Loss in LOCKED.** Drop lock → `reset_out`=1 two edges later, a 4-cycle `pll_rst_out` pulse, `lock_loss_count`=1. Repeat 300 losses → count holds at 255.
- **restart_req cases.**
  - In FAILED → `lock_fail`=0 and `pll_rst_out`=1 from the next edge, for 4 cycles.
  - Coincident with a lock loss → `lock_loss_count` is unchanged.
  - Mid-RESET_PLL → the hold restarts at a full 4 cycles.
- **Async reset mid-STABILIZE.** Assert `reset_n` between edges → all outputs take reset values immediately without a clock edge; the sequence restarts cleanly after release.
